// File: rtl/packet_receiver.sv
// Packet receiver: decodes 13-bit packets, checks parity, and buffers them in a FIFO with statistics counters.
// Optional sequence checker built when PKT_RX_SEQ_CHECK_EN is defined.
module packet_receiver #(
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dd_valid,
    output logic             dd_ready,
    input  logic [12:0]      packet,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_id,
    output logic [7:0]       out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] rx_count,
    output logic [CNT_W-1:0] err_count,
    output logic             seq_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    typedef struct packed {
        logic [3:0] id;
        logic [7:0] data;
        logic       err;
    } entry_t;

    localparam cnt_t             FULL     = cnt_t'(DEPTH);
    localparam cnt_t             CNT_INC  = cnt_t'(1);
    localparam ptr_t             PTR_INC  = ptr_t'(1);
    localparam logic [CNT_W-1:0] STAT_INC = CNT_W'(1);
    localparam logic             GOOD_PAR = (PARITY_ODD != 0);

    entry_t mem [DEPTH];
    ptr_t   wr_ptr, rd_ptr;
    cnt_t   count;
    logic   live;
    logic   push, pop, perr, err_hit;
    entry_t head;

    assign perr      = ((^packet) != GOOD_PAR);
    assign dd_ready  = live && (count != FULL);
    assign out_valid = (count != '0);
    assign push      = dd_valid && dd_ready;
    assign pop       = out_valid && out_ready;
    assign head      = mem[rd_ptr];

    // Gate the head fields so every output reads 0 while the FIFO is empty or in reset.
    assign out_id   = out_valid ? head.id   : '0;
    assign out_data = out_valid ? head.data : '0;
    assign out_err  = out_valid ? head.err  : 1'b0;

    // NOTE: storage array is deliberately left unreset; count gates validity, so clearing it would only cost reset fanout.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{id: packet[12:9], data: packet[8:1], err: perr};
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live      <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rx_count  <= '0;
            err_count <= '0;
        end else begin
            live <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PTR_INC;
            if (pop)  rd_ptr <= rd_ptr + PTR_INC;
            case ({push, pop})
                2'b10:   count <= count + CNT_INC;
                2'b01:   count <= count - CNT_INC;
                default: count <= count;
            endcase
            if (push && (rx_count != '1))             rx_count  <= rx_count + STAT_INC;
            if (push && err_hit && (err_count != '1)) err_count <= err_count + STAT_INC;
        end
    end

`ifdef PKT_RX_SEQ_CHECK_EN
    typedef enum logic {SYNC, LOCKED} seq_state_e;

    seq_state_e state_q, state_d;
    logic [3:0] exp_id_q, exp_id_d;
    logic       seq_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= SYNC;
            exp_id_q <= '0;
            seq_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_id_q <= exp_id_d;
            seq_err  <= seq_hit;
        end
    end

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        exp_id_d = exp_id_q;
        seq_hit  = 1'b0;
        if (push && !perr) begin
            exp_id_d = packet[12:9] + 4'd1;
            state_d  = LOCKED;
            if (state_q == LOCKED && packet[12:9] != exp_id_q) seq_hit = 1'b1;
        end
    end

    assign err_hit = perr || seq_hit;
`else
    assign seq_err = 1'b0;
    assign err_hit = perr;
`endif

endmodule

// File: tb/tb_packet_receiver.sv
// Directed self-checking bench for packet_receiver (default parameters).
module tb_packet_receiver;

    logic        clk;
    logic        rst;
    logic        dd_valid;
    logic        dd_ready;
    logic [12:0] packet;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_id;
    logic [7:0]  out_data;
    logic        out_err;
    logic [15:0] rx_count;
    logic [15:0] err_count;
    logic        seq_err;

    int total = 0;
    int bad   = 0;

    packet_receiver dut (
        .clk(clk), .rst(rst), .dd_valid(dd_valid), .dd_ready(dd_ready), .packet(packet),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_data(out_data),
        .out_err(out_err), .rx_count(rx_count), .err_count(err_count), .seq_err(seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] mk(input logic [3:0] id, input logic [7:0] d, input logic flip);
        logic p;
        p = (^{id, d}) ^ flip;
        return {id, d, p};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; dd_valid = 1'b0; out_ready = 1'b0; packet = '0;
        step(); step();
        total++; if (dd_ready !== 1'b0)  begin bad++; $display("FAIL reset_dd_ready got=%b exp=0", dd_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if ({out_id, out_data, out_err} !== 13'd0) begin bad++; $display("FAIL reset_out_fields got=%h exp=0", {out_id, out_data, out_err}); end
        total++; if ({rx_count, err_count} !== 32'd0) begin bad++; $display("FAIL reset_counters got=%h exp=0", {rx_count, err_count}); end
        total++; if (seq_err !== 1'b0)   begin bad++; $display("FAIL reset_seq_err got=%b exp=0", seq_err); end
        rst = 1'b1;
        step();
        total++; if (dd_ready !== 1'b1)  begin bad++; $display("FAIL release_dd_ready got=%b exp=1", dd_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_single();
        out_ready = 1'b1; dd_valid = 1'b1; packet = 13'h034B;
        step();
        dd_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        total++; if (out_id !== 4'd1)    begin bad++; $display("FAIL single_id got=%h exp=1", out_id); end
        total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", out_data); end
        total++; if (out_err !== 1'b0)   begin bad++; $display("FAIL single_err got=%b exp=0", out_err); end
        total++; if (rx_count !== 16'd1) begin bad++; $display("FAIL single_rx got=%0d exp=1", rx_count); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dd_valid = 1'b1; packet = mk(4'(2 + i), 8'(8'h10 + i), 1'b0);
            step();
        end
        total++; if (dd_ready !== 1'b0) begin bad++; $display("FAIL full_dd_ready got=%b exp=0", dd_ready); end
        total++; if (out_id !== 4'd2)   begin bad++; $display("FAIL full_head got=%h exp=2", out_id); end
        packet = mk(4'd6, 8'h14, 1'b0);
        step(); step();
        total++; if (rx_count !== 16'd5) begin bad++; $display("FAIL full_hold_rx got=%0d exp=5", rx_count); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (dd_ready !== 1'b1)  begin bad++; $display("FAIL pop_dd_ready got=%b exp=1", dd_ready); end
        total++; if (out_id !== 4'd3)    begin bad++; $display("FAIL pop_head got=%h exp=3", out_id); end
        step();
        dd_valid = 1'b0;
        total++; if (rx_count !== 16'd6) begin bad++; $display("FAIL fifth_rx got=%0d exp=6", rx_count); end
        total++; if (dd_ready !== 1'b0)  begin bad++; $display("FAIL refull_dd_ready got=%b exp=0", dd_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_id !== 4'(3 + i) || out_data !== 8'(8'h11 + i)) begin
                bad++; $display("FAIL drain_%0d got=%b/%h/%h exp=1/%h/%h", i, out_valid, out_id, out_data, 4'(3 + i), 8'(8'h11 + i));
            end
            step();
        end
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_parity();
        dd_valid = 1'b1; packet = 13'h034A;
        step();
        dd_valid = 1'b0;
        total++; if (out_err !== 1'b1)    begin bad++; $display("FAIL parity_err got=%b exp=1", out_err); end
        total++; if (out_data !== 8'hA5)  begin bad++; $display("FAIL parity_data got=%h exp=a5", out_data); end
        total++; if (err_count !== 16'd1) begin bad++; $display("FAIL parity_err_count got=%0d exp=1", err_count); end
        total++; if (rx_count !== 16'd7)  begin bad++; $display("FAIL parity_rx got=%0d exp=7", rx_count); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            dd_valid = 1'b1; packet = mk(4'(7 + i), 8'(8'hC0 + i), 1'b0);
            step();
        end
        total++; if (out_id !== 4'd7) begin bad++; $display("FAIL b2b_head got=%h exp=7", out_id); end
        packet = mk(4'd9, 8'hC2, 1'b0); out_ready = 1'b1;
        step();
        dd_valid = 1'b0;
        total++; if (out_id !== 4'd8 || out_data !== 8'hC1) begin bad++; $display("FAIL b2b_advance got=%h/%h exp=8/c1", out_id, out_data); end
        total++; if (rx_count !== 16'd10) begin bad++; $display("FAIL b2b_rx got=%0d exp=10", rx_count); end
        step();
        total++; if (out_valid !== 1'b1 || out_id !== 4'd9) begin bad++; $display("FAIL b2b_second got=%b/%h exp=1/9", out_valid, out_id); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_count got=%b exp=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 2; i++) begin
            dd_valid = 1'b1; packet = mk(4'(10 + i), 8'h55, 1'b0);
            step();
        end
        dd_valid = 1'b0;
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || dd_ready !== 1'b0) begin bad++; $display("FAIL midrst_hs got=%b/%b exp=0/0", out_valid, dd_ready); end
        total++; if ({rx_count, err_count} !== 32'd0) begin bad++; $display("FAIL midrst_counters got=%h exp=0", {rx_count, err_count}); end
        step();
        rst = 1'b1;
        step();
        total++; if (dd_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL midrst_release got=%b/%b exp=1/0", dd_ready, out_valid); end
    endtask

    task automatic test_seq();
        logic [3:0] ids [3];
        logic       exp_pulse;
        logic [15:0] exp_err;
        ids[0] = 4'd3; ids[1] = 4'd4; ids[2] = 4'd6;
`ifdef PKT_RX_SEQ_CHECK_EN
        exp_pulse = 1'b1; exp_err = 16'd1;
`else
        exp_pulse = 1'b0; exp_err = 16'd0;
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dd_valid = 1'b1; packet = mk(ids[i], 8'h3C, 1'b0);
            step();
            total++;
            if (seq_err !== ((i == 2) ? exp_pulse : 1'b0)) begin
                bad++; $display("FAIL seq_pulse_%0d got=%b exp=%b", i, seq_err, (i == 2) ? exp_pulse : 1'b0);
            end
        end
        dd_valid = 1'b0;
        step();
        total++; if (seq_err !== 1'b0)     begin bad++; $display("FAIL seq_pulse_width got=%b exp=0", seq_err); end
        total++; if (err_count !== exp_err) begin bad++; $display("FAIL seq_err_count got=%0d exp=%0d", err_count, exp_err); end
        total++; if (rx_count !== 16'd3)   begin bad++; $display("FAIL seq_rx got=%0d exp=3", rx_count); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_parity();
        test_back_to_back();
        test_mid_reset();
        test_seq();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
